// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register address width, register-file clear FSM states,
// and the architectural register legality check.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } regfile_state_t;

  function automatic logic is_legal_reg(input logic [REG_ADDR_W-1:0] addr, input int num_regs);
    return int'({27'd0, addr}) < num_regs;
  endfunction

endpackage

// File: rtl/cpu_regfile_scoreboard.sv
// Per-register pending bits for hazard detection. Precedence at the edge:
// clear_all beats everything, and an issue beats a same-register write.
module cpu_regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear_all,
  input  logic                        set_en,
  input  logic [REG_ADDR_W-1:0]       set_addr,
  input  logic                        clr_en,
  input  logic [REG_ADDR_W-1:0]       clr_addr,
  output logic [(1<<REG_ADDR_W)-1:0]  pending
);

  localparam int SB_W = 1 << REG_ADDR_W;

  logic [SB_W-1:0] pend_q, pend_d;
  logic            set_ok, clr_ok;

  assign set_ok = set_en && (set_addr != '0) && is_legal_reg(set_addr, NUM_REGS);
  assign clr_ok = clr_en && is_legal_reg(clr_addr, NUM_REGS);

  always_comb begin
    pend_d = pend_q;
    if (clear_all) begin
      pend_d = '0;
    end else begin
      if (clr_ok) pend_d[clr_addr] = 1'b0;
      if (set_ok) pend_d[set_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pend_q <= '0;
    else          pend_q <= pend_d;
  end

  assign pending = pend_q;

endmodule

// File: rtl/cpu_regfile_mp.sv
// Multi-port integer register file with optional write bypass, pending scoreboard
// and a sequential clear engine used by flush/trap handling.
module cpu_regfile_mp
  import cpu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_RD*REG_ADDR_W-1:0] rs_addr,
  output logic [NUM_RD*XLEN-1:0]       rs_data,
  output logic [NUM_RD-1:0]            rs_pending,
  input  logic [REG_ADDR_W-1:0]        rd_addr,
  input  logic [XLEN-1:0]              rd_data,
  input  logic                         rd_write_en,
  input  logic                         issue_en,
  input  logic [REG_ADDR_W-1:0]        issue_addr,
  input  logic                         clear_req,
  output logic                         busy,
  output logic                         clear_done,
  output logic                         illegal_addr,
  output logic                         dbg_state
);

  // Storage spans the full address space so any 5-bit address indexes safely;
  // entries at or above NUM_REGS are never written and hold zero.
  localparam int ARR_N = 1 << REG_ADDR_W;

  logic [XLEN-1:0]       regs_q [ARR_N];
  logic [XLEN-1:0]       regs_d [ARR_N];
  regfile_state_t        state_q, state_d;
  logic [REG_ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic                  clear_done_q, clear_done_d;
  logic                  wr_acc, start_clear, clr_last;
  logic [ARR_N-1:0]      pending;
  logic [NUM_RD-1:0]     rs_illegal;

  // Handshake-free interface: rd_write_en/issue_en are single-cycle strobes that are
  // accepted only in IDLE; anything presented while busy is dropped, not held.
  assign wr_acc      = rd_write_en && (state_q == RF_IDLE) && (rd_addr != '0) &&
                       is_legal_reg(rd_addr, NUM_REGS);
  assign start_clear = (state_q == RF_IDLE) && clear_req;
  assign clr_last    = int'({27'd0, clr_idx_q}) == NUM_REGS - 1;

  always_comb begin
    regs_d       = regs_q;
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    clear_done_d = 1'b0;
    case (state_q)
      RF_IDLE: begin
        if (wr_acc) regs_d[rd_addr] = rd_data;
        if (clear_req) begin
          state_d   = RF_CLEAR;
          clr_idx_d = 5'd1;
        end
      end
      RF_CLEAR: begin
        regs_d[clr_idx_q] = '0;
        clr_idx_d         = clr_idx_q + 5'd1;
        if (clr_last) begin
          state_d      = RF_IDLE;
          clr_idx_d    = 5'd1;
          clear_done_d = 1'b1;
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RF_IDLE;
      clr_idx_q    <= 5'd1;
      clear_done_q <= 1'b0;
      for (int r = 0; r < ARR_N; r++) regs_q[r] <= '0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      clear_done_q <= clear_done_d;
      regs_q       <= regs_d;
    end
  end

  cpu_regfile_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_all (start_clear),
    .set_en    (issue_en && (state_q == RF_IDLE)),
    .set_addr  (issue_addr),
    .clr_en    (wr_acc),
    .clr_addr  (rd_addr),
    .pending   (pending)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [REG_ADDR_W-1:0] a;
    logic                  legal, hit;
    assign a     = rs_addr[REG_ADDR_W*i +: REG_ADDR_W];
    assign legal = is_legal_reg(a, NUM_REGS);
    assign hit   = (BYPASS != 0) && wr_acc && (rd_addr == a);
    assign rs_illegal[i] = !legal;
    assign rs_data[XLEN*i +: XLEN] = hit ? rd_data :
                                     (legal && (a != '0)) ? regs_q[a] : '0;
    // Pending is the registered bit only; a clearing write shows up next cycle.
    assign rs_pending[i] = legal && (a != '0) && pending[a];
  end

  assign illegal_addr = (|rs_illegal) ||
                        (rd_write_en && !is_legal_reg(rd_addr, NUM_REGS)) ||
                        (issue_en && !is_legal_reg(issue_addr, NUM_REGS));
  assign busy       = (state_q == RF_CLEAR);
  assign clear_done = clear_done_q;
  assign dbg_state  = state_q;

endmodule
